// File: rtl/vm_param_change_if.sv
// Front-panel, supplier and dispenser signals of the vending controller.
interface vm_param_change_if #(
    parameter int unsigned N_ITEMS = 6,
    parameter int unsigned COST_W  = 8,
    parameter int unsigned COUNT_W = 4,
    parameter int unsigned BAL_W   = 10
);
    localparam int unsigned IDX_W = $clog2(N_ITEMS);

    logic               sup_valid;
    logic               sup_ready;
    logic [IDX_W-1:0]   sup_item;
    logic [COUNT_W-1:0] sup_count;
    logic [COST_W-1:0]  sup_cost;
    logic [1:0]         coin;
    logic               coin_reject;
    logic [N_ITEMS-1:0] sel;
    logic               enter_key;
    logic               soft_rst;
    logic               product_valid;
    logic [IDX_W-1:0]   product_id;
    logic               change_valid;
    logic [1:0]         change_coin;
    logic [BAL_W-1:0]   balance;
    logic [COST_W-1:0]  info;
    logic [2:0]         status;

    // Panel / supplier side drives requests and observes the controller.
    modport master (
        output sup_valid, sup_item, sup_count, sup_cost, coin, sel, enter_key, soft_rst,
        input  sup_ready, coin_reject, product_valid, product_id, change_valid,
               change_coin, balance, info, status
    );

    // Controller side.
    modport slave (
        input  sup_valid, sup_item, sup_count, sup_cost, coin, sel, enter_key, soft_rst,
        output sup_ready, coin_reject, product_valid, product_id, change_valid,
               change_coin, balance, info, status
    );
endinterface

// File: rtl/vm_param_change.sv
// Vending controller: coin credit, single-select purchase, supplier load and greedy change return.
module vm_param_change #(
    parameter int unsigned N_ITEMS     = 6,
    parameter int unsigned COST_W      = 8,
    parameter int unsigned COUNT_W     = 4,
    parameter int unsigned BAL_W       = 10,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic              clk,
    input logic              rst,
    vm_param_change_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(N_ITEMS);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned MAX_W = (BAL_W > COST_W) ? BAL_W : COST_W;
    localparam int unsigned CMP_W = ((MAX_W > 5) ? MAX_W : 5) + 1;

    localparam logic [CMP_W-1:0] BAL_MAX  = CMP_W'((64'd1 << BAL_W) - 64'd1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_PROC    = 3'b001;
    localparam logic [2:0] ST_VENDED  = 3'b010;
    localparam logic [2:0] ST_SOLD    = 3'b011;
    localparam logic [2:0] ST_INSUF   = 3'b100;
    localparam logic [2:0] ST_MULTI   = 3'b101;
    localparam logic [2:0] ST_CANCEL  = 3'b110;
    localparam logic [2:0] ST_LOADERR = 3'b111;

    localparam logic [1:0] COIN_5  = 2'b01;
    localparam logic [1:0] COIN_10 = 2'b10;
    localparam logic [1:0] COIN_25 = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_VEND, S_CHANGE} state_t;

    state_t             state_q, state_d;
    logic [BAL_W-1:0]   bal_q, bal_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               sup_ready_q, sup_ready_d;
    logic               coin_reject_q, coin_reject_d;
    logic               product_valid_q, product_valid_d;
    logic [IDX_W-1:0]   product_id_q, product_id_d;
    logic               change_valid_q, change_valid_d;
    logic [1:0]         change_coin_q, change_coin_d;
    logic [COST_W-1:0]  info_q, info_d;
    logic [2:0]         status_q, status_d;

    logic [COUNT_W-1:0] cnt_q  [N_ITEMS];
    logic [COST_W-1:0]  cost_q [N_ITEMS];
    logic               cnt_we, cost_we;
    logic [IDX_W-1:0]   wr_idx;
    logic [COUNT_W-1:0] cnt_wdata;
    logic [COST_W-1:0]  cost_wdata;

    logic [IDX_W:0]     sel_cnt;
    logic [IDX_W-1:0]   sel_idx;
    logic [CMP_W-1:0]   coin_val;
    logic [CMP_W-1:0]   bal_sum;
    logic [CMP_W-1:0]   bal_acc_ext;
    logic [CMP_W-1:0]   cost_ext;
    logic [CMP_W-1:0]   chg_val;
    logic [BAL_W-1:0]   bal_acc;
    logic               coin_acc;
    logic               load_bad;

    // Button popcount and index of the pressed button (meaningful when exactly one is pressed).
    always_comb begin
        sel_cnt = '0;
        sel_idx = '0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (bus.sel[i]) begin
                sel_cnt = sel_cnt + (IDX_W+1)'(1);
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Coin decode, load validation and the greedy change coin for the current balance.
    always_comb begin
        coin_val = '0;
        case (bus.coin)
            COIN_5:  coin_val = CMP_W'(5);
            COIN_10: coin_val = CMP_W'(10);
            COIN_25: coin_val = CMP_W'(25);
            default: coin_val = '0;
        endcase
        bal_sum  = CMP_W'(bal_q) + coin_val;
        load_bad = ({1'b0, bus.sup_item} >= (IDX_W+1)'(N_ITEMS)) ||
                   ((bus.sup_cost % COST_W'(5)) != '0);
        cost_ext = CMP_W'(cost_q[idx_q]);
        if (CMP_W'(bal_q) >= CMP_W'(25)) begin
            chg_val       = CMP_W'(25);
            change_coin_d = COIN_25;
        end else if (CMP_W'(bal_q) >= CMP_W'(10)) begin
            chg_val       = CMP_W'(10);
            change_coin_d = COIN_10;
        end else begin
            chg_val       = CMP_W'(5);
            change_coin_d = COIN_5;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d         = state_q;
        bal_d           = bal_q;
        idx_d           = idx_q;
        tmr_d           = tmr_q;
        coin_reject_d   = 1'b0;
        product_valid_d = 1'b0;
        product_id_d    = '0;
        change_valid_d  = 1'b0;
        info_d          = info_q;
        status_d        = status_q;
        cnt_we          = 1'b0;
        cost_we         = 1'b0;
        wr_idx          = idx_q;
        cnt_wdata       = '0;
        cost_wdata      = '0;
        coin_acc        = 1'b0;
        bal_acc         = bal_q;

        // Credit is taken only while the customer can still shop; saturation refuses the coin.
        if (bus.coin != 2'b00) begin
            if ((state_q == S_IDLE || state_q == S_SELECT) && bal_sum <= BAL_MAX) begin
                coin_acc = 1'b1;
                bal_acc  = BAL_W'(bal_sum);
            end else begin
                coin_reject_d = 1'b1;
            end
        end
        bal_d       = bal_acc;
        bal_acc_ext = CMP_W'(bal_acc);

        case (state_q)
            S_IDLE: begin
                if (bus.sup_valid && sup_ready_q) begin
                    if (load_bad) begin
                        status_d = ST_LOADERR;
                    end else begin
                        cnt_we     = 1'b1;
                        cost_we    = 1'b1;
                        wr_idx     = bus.sup_item;
                        cnt_wdata  = bus.sup_count;
                        cost_wdata = bus.sup_cost;
                    end
                end else if (sel_cnt == (IDX_W+1)'(1)) begin
                    idx_d    = sel_idx;
                    info_d   = cost_q[sel_idx];
                    status_d = ST_PROC;
                    tmr_d    = '0;
                    state_d  = S_SELECT;
                end else if (sel_cnt > (IDX_W+1)'(1)) begin
                    status_d = ST_MULTI;
                end
            end
            S_SELECT: begin
                if (bus.soft_rst || tmr_q == TMR_LAST) begin
                    status_d = ST_CANCEL;
                    if (bal_acc == '0) begin
                        state_d = S_IDLE;
                        info_d  = '0;
                    end else begin
                        state_d = S_CHANGE;
                    end
                end else if (cnt_q[idx_q] == '0) begin
                    status_d = ST_SOLD;
                    if (bal_acc == '0) begin
                        state_d = S_IDLE;
                        info_d  = '0;
                    end else begin
                        state_d = S_CHANGE;
                    end
                end else if (bus.enter_key && bal_acc_ext >= cost_ext) begin
                    state_d         = S_VEND;
                    product_valid_d = 1'b1;
                    product_id_d    = idx_q;
                    cnt_we          = 1'b1;
                    wr_idx          = idx_q;
                    cnt_wdata       = cnt_q[idx_q] - COUNT_W'(1);
                    bal_d           = BAL_W'(bal_acc_ext - cost_ext);
                    status_d        = ST_VENDED;
                    info_d          = '0;
                end else begin
                    if (bus.enter_key) begin
                        status_d = ST_INSUF;
                    end
                    tmr_d = (bus.enter_key || coin_acc) ? '0 : tmr_q + TMR_W'(1);
                end
            end
            S_VEND: begin
                state_d = (bal_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                if (bal_q == '0) begin
                    state_d = S_IDLE;
                    info_d  = '0;
                end else begin
                    change_valid_d = 1'b1;
                    bal_d          = BAL_W'(CMP_W'(bal_q) - chg_val);
                    if (CMP_W'(bal_q) == chg_val) begin
                        state_d = S_IDLE;
                        info_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        sup_ready_d = (state_d == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            bal_q           <= '0;
            idx_q           <= '0;
            tmr_q           <= '0;
            sup_ready_q     <= 1'b0;
            coin_reject_q   <= 1'b0;
            product_valid_q <= 1'b0;
            product_id_q    <= '0;
            change_valid_q  <= 1'b0;
            change_coin_q   <= 2'b00;
            info_q          <= '0;
            status_q        <= ST_IDLE;
        end else begin
            state_q         <= state_d;
            bal_q           <= bal_d;
            idx_q           <= idx_d;
            tmr_q           <= tmr_d;
            sup_ready_q     <= sup_ready_d;
            coin_reject_q   <= coin_reject_d;
            product_valid_q <= product_valid_d;
            product_id_q    <= product_id_d;
            change_valid_q  <= change_valid_d;
            change_coin_q   <= change_valid_d ? change_coin_d : 2'b00;
            info_q          <= info_d;
            status_q        <= status_d;
        end
    end

    // Inventory table: stock counts and prices per slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_ITEMS; i++) begin
                cnt_q[i]  <= '0;
                cost_q[i] <= '0;
            end
        end else begin
            if (cnt_we) begin
                cnt_q[wr_idx] <= cnt_wdata;
            end
            if (cost_we) begin
                cost_q[wr_idx] <= cost_wdata;
            end
        end
    end

    assign bus.sup_ready     = sup_ready_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.product_valid = product_valid_q;
    assign bus.product_id    = product_id_q;
    assign bus.change_valid  = change_valid_q;
    assign bus.change_coin   = change_coin_q;
    assign bus.balance       = bal_q;
    assign bus.info          = info_q;
    assign bus.status        = status_q;
endmodule

// File: tb/tb_vm_param_change.sv
// Bench for vm_param_change: directed scenarios plus randomized purchases against a transaction-level model.
module tb_vm_param_change;
    localparam int unsigned N_ITEMS     = 6;
    localparam int unsigned COST_W      = 8;
    localparam int unsigned COUNT_W     = 4;
    localparam int unsigned BAL_W       = 10;
    localparam int unsigned TIMEOUT_CYC = 64;
    localparam int unsigned IDX_W       = $clog2(N_ITEMS);
    localparam int          BAL6_MAX    = 63;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vm_param_change_if #(.N_ITEMS(N_ITEMS), .COST_W(COST_W), .COUNT_W(COUNT_W), .BAL_W(BAL_W)) bus ();
    vm_param_change_if #(.N_ITEMS(N_ITEMS), .COST_W(COST_W), .COUNT_W(COUNT_W), .BAL_W(6)) bus6 ();

    vm_param_change #(.N_ITEMS(N_ITEMS), .COST_W(COST_W), .COUNT_W(COUNT_W), .BAL_W(BAL_W),
                      .TIMEOUT_CYC(TIMEOUT_CYC)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    vm_param_change #(.N_ITEMS(N_ITEMS), .COST_W(COST_W), .COUNT_W(COUNT_W), .BAL_W(6),
                      .TIMEOUT_CYC(TIMEOUT_CYC)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

    int checks = 0;
    int errors = 0;

    // Reference model: inventory, credit and last reported status.
    int m_cnt  [N_ITEMS];
    int m_cost [N_ITEMS];
    int m_bal;
    int m_status;

    function automatic int coin_value(input int code);
        case (code)
            1: return 5;
            2: return 10;
            3: return 25;
            default: return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.sup_valid = 1'b0; bus.sup_item = '0; bus.sup_count = '0; bus.sup_cost = '0;
        bus.coin = 2'b00; bus.sel = '0; bus.enter_key = 1'b0; bus.soft_rst = 1'b0;
        bus6.sup_valid = 1'b0; bus6.sup_item = '0; bus6.sup_count = '0; bus6.sup_cost = '0;
        bus6.coin = 2'b00; bus6.sel = '0; bus6.enter_key = 1'b0; bus6.soft_rst = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N_ITEMS; i++) begin
            m_cnt[i]  = 0;
            m_cost[i] = 0;
        end
        m_bal    = 0;
        m_status = 0;
    endtask

    task automatic do_load(input int item, input int count, input int cost);
        bus.sup_valid = 1'b1;
        bus.sup_item  = IDX_W'(item);
        bus.sup_count = COUNT_W'(count);
        bus.sup_cost  = COST_W'(cost);
        step();
        bus.sup_valid = 1'b0;
        if (item >= N_ITEMS || cost % 5 != 0) begin
            m_status = 7;
        end else begin
            m_cnt[item]  = count;
            m_cost[item] = cost;
        end
        checks++;
        if (bus.status !== 3'(m_status)) begin
            errors++;
            $display("FAIL load_status item=%0d cost=%0d: got %0d expected %0d", item, cost, bus.status, m_status);
        end
    endtask

    task automatic add_coin(input int code);
        int   v;
        logic rej;
        v = coin_value(code);
        bus.coin = 2'(code);
        step();
        bus.coin = 2'b00;
        rej = (m_bal + v > (1 << BAL_W) - 1);
        if (!rej) m_bal += v;
        checks++;
        if (bus.coin_reject !== rej || bus.balance !== BAL_W'(m_bal)) begin
            errors++;
            $display("FAIL coin code=%0d: got reject=%0b balance=%0d expected reject=%0b balance=%0d",
                     code, bus.coin_reject, bus.balance, rej, m_bal);
        end
    endtask

    task automatic select_one(input int idx);
        logic [N_ITEMS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        bus.sel = v;
        step();
        bus.sel = '0;
        m_status = 1;
        checks++;
        if (bus.status !== 3'd1 || bus.info !== COST_W'(m_cost[idx]) || bus.sup_ready !== 1'b0) begin
            errors++;
            $display("FAIL select slot=%0d: got status=%0d info=%0d ready=%0b expected status=1 info=%0d ready=0",
                     idx, bus.status, bus.info, bus.sup_ready, m_cost[idx]);
        end
    endtask

    // Steps until the machine is idle, collecting change coins; checks them against the greedy refund.
    task automatic drain(input string tag);
        int exp_q[$];
        int got_q[$];
        int r;
        int cyc;
        int pv;
        int got_sum;
        bit same;
        r = m_bal;
        while (r > 0) begin
            if (r >= 25) begin exp_q.push_back(3); r -= 25; end
            else if (r >= 10) begin exp_q.push_back(2); r -= 10; end
            else begin exp_q.push_back(1); r -= 5; end
        end
        cyc = 0;
        pv = 0;
        got_sum = 0;
        do begin
            step();
            cyc++;
            if (bus.change_valid === 1'b1) begin
                got_q.push_back(int'(bus.change_coin));
                got_sum += coin_value(int'(bus.change_coin));
            end
            if (bus.product_valid === 1'b1) pv++;
        end while (!(bus.sup_ready === 1'b1 && bus.change_valid === 1'b0) && cyc < 200);
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL %s idle_timeout: got %0d cycles expected under 200", tag, cyc);
        end
        same = (got_q.size() == exp_q.size());
        if (same) foreach (exp_q[i]) if (got_q[i] != exp_q[i]) same = 1'b0;
        checks++;
        if (!same) begin
            errors++;
            $display("FAIL %s change_seq: got %0d coins worth %0d expected %0d coins worth %0d",
                     tag, got_q.size(), got_sum, exp_q.size(), m_bal);
        end
        m_bal = 0;
        checks++;
        if (bus.balance !== '0 || bus.info !== '0 || bus.status !== 3'(m_status) || pv != 0) begin
            errors++;
            $display("FAIL %s end_state: got balance=%0d info=%0d status=%0d extra_pv=%0d expected 0 0 %0d 0",
                     tag, bus.balance, bus.info, bus.status, pv, m_status);
        end
    endtask

    task automatic buy(input int idx);
        bus.enter_key = 1'b1;
        step();
        bus.enter_key = 1'b0;
        m_bal -= m_cost[idx];
        m_cnt[idx]--;
        m_status = 2;
        checks++;
        if (bus.product_valid !== 1'b1 || bus.product_id !== IDX_W'(idx) || bus.status !== 3'd2 ||
            bus.info !== '0 || bus.balance !== BAL_W'(m_bal)) begin
            errors++;
            $display("FAIL vend slot=%0d: got pv=%0b id=%0d status=%0d info=%0d bal=%0d expected 1 %0d 2 0 %0d",
                     idx, bus.product_valid, bus.product_id, bus.status, bus.info, bus.balance, idx, m_bal);
        end
        drain("vend");
    endtask

    task automatic enter_short();
        bus.enter_key = 1'b1;
        step();
        bus.enter_key = 1'b0;
        m_status = 4;
        checks++;
        if (bus.status !== 3'd4 || bus.sup_ready !== 1'b0 || bus.product_valid !== 1'b0) begin
            errors++;
            $display("FAIL insufficient: got status=%0d ready=%0b pv=%0b expected 4 0 0",
                     bus.status, bus.sup_ready, bus.product_valid);
        end
    endtask

    task automatic cancel();
        bus.soft_rst = 1'b1;
        step();
        bus.soft_rst = 1'b0;
        m_status = 6;
        checks++;
        if (bus.status !== 3'd6) begin
            errors++;
            $display("FAIL cancel_status: got %0d expected 6", bus.status);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (bus.sup_ready !== 1'b0 || bus.balance !== '0 || bus.status !== 3'd0 || bus.info !== '0 ||
            bus.product_valid !== 1'b0 || bus.change_valid !== 1'b0 || bus.coin_reject !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%0b bal=%0d status=%0d info=%0d expected all 0",
                     bus.sup_ready, bus.balance, bus.status, bus.info);
        end
        rst = 1'b1;
        step();
        step();
        checks++;
        if (bus.sup_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %0b expected 1", bus.sup_ready);
        end
    endtask

    task automatic test_basic_vend();
        do_load(2, 3, 75);
        add_coin(3); add_coin(3); add_coin(3); add_coin(2);
        select_one(2);
        buy(2);
    endtask

    task automatic test_insufficient();
        add_coin(3); add_coin(3);
        select_one(2);
        enter_short();
        add_coin(3);
        buy(2);
    endtask

    task automatic test_multi_select();
        add_coin(3); add_coin(1);
        bus.sel = N_ITEMS'(6'b000101);
        step();
        bus.sel = '0;
        m_status = 5;
        checks++;
        if (bus.status !== 3'd5 || bus.balance !== BAL_W'(m_bal) || bus.sup_ready !== 1'b1) begin
            errors++;
            $display("FAIL multi_select: got status=%0d bal=%0d ready=%0b expected 5 %0d 1",
                     bus.status, bus.balance, bus.sup_ready, m_bal);
        end
        bus.sel = N_ITEMS'(6'b000001);
        bus.sup_valid = 1'b1; bus.sup_item = '0; bus.sup_count = COUNT_W'(2); bus.sup_cost = COST_W'(20);
        step();
        bus.sel = '0;
        bus.sup_valid = 1'b0;
        m_cnt[0] = 2;
        m_cost[0] = 20;
        checks++;
        if (bus.sup_ready !== 1'b1 || bus.status !== 3'd5 || bus.info !== '0) begin
            errors++;
            $display("FAIL load_beats_sel: got ready=%0b status=%0d info=%0d expected 1 5 0",
                     bus.sup_ready, bus.status, bus.info);
        end
    endtask

    task automatic test_sold_out();
        do_load(4, 0, 40);
        select_one(4);
        m_status = 3;
        drain("soldout_slot4");
        add_coin(3); add_coin(3); add_coin(3);
        select_one(2);
        buy(2);
        add_coin(2);
        select_one(2);
        m_status = 3;
        drain("soldout_slot2");
    endtask

    task automatic test_timeout();
        do_load(1, 2, 50);
        add_coin(2); add_coin(2);
        select_one(1);
        repeat (TIMEOUT_CYC - 1) step();
        checks++;
        if (bus.status !== 3'd1 || bus.sup_ready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got status=%0d ready=%0b expected 1 0", bus.status, bus.sup_ready);
        end
        step();
        m_status = 6;
        checks++;
        if (bus.status !== 3'd6) begin
            errors++;
            $display("FAIL timeout_fire: got status=%0d expected 6", bus.status);
        end
        drain("timeout");
    endtask

    task automatic test_soft_rst();
        add_coin(2); add_coin(2);
        select_one(1);
        repeat (3) step();
        cancel();
        drain("soft_rst");
    endtask

    task automatic test_load_error();
        do_load(1, 5, 77);
        do_load(7, 1, 50);
        select_one(1);
        cancel();
        drain("load_err");
    endtask

    task automatic test_overflow();
        int   b6;
        int   v;
        logic rej;
        int   codes [5];
        codes = '{3, 3, 2, 1, 2};
        b6 = 0;
        foreach (codes[i]) begin
            v = coin_value(codes[i]);
            bus6.coin = 2'(codes[i]);
            step();
            bus6.coin = 2'b00;
            rej = (b6 + v > BAL6_MAX);
            if (!rej) b6 += v;
            checks++;
            if (bus6.coin_reject !== rej || bus6.balance !== 6'(b6)) begin
                errors++;
                $display("FAIL overflow coin=%0d: got reject=%0b bal=%0d expected reject=%0b bal=%0d",
                         codes[i], bus6.coin_reject, bus6.balance, rej, b6);
            end
        end
    endtask

    task automatic test_random();
        int idx;
        int cost;
        int cnt;
        int n_pre;
        bit want_short;
        for (int it = 0; it < 8; it++) begin
            idx  = int'($urandom_range(N_ITEMS - 1, 0));
            cost = 5 * int'($urandom_range(20, 1));
            cnt  = int'($urandom_range(3, 1));
            do_load(idx, cnt, cost);
            n_pre = int'($urandom_range(2, 0));
            for (int k = 0; k < n_pre; k++) add_coin(int'($urandom_range(3, 1)));
            select_one(idx);
            want_short = ($urandom_range(2, 0) == 0);
            while (m_bal < cost) begin
                if (want_short) begin
                    enter_short();
                    want_short = 1'b0;
                end
                add_coin(int'($urandom_range(3, 1)));
            end
            buy(idx);
            if (m_cnt[idx] == 0) begin
                select_one(idx);
                m_status = 3;
                drain("rand_soldout");
            end
        end
    endtask

    task automatic test_reset_in_change();
        do_load(3, 2, 20);
        add_coin(3); add_coin(3); add_coin(3); add_coin(3);
        select_one(3);
        cancel();
        bus.coin = 2'b01;
        step();
        bus.coin = 2'b00;
        checks++;
        if (bus.coin_reject !== 1'b1 || bus.change_valid !== 1'b1 || bus.change_coin !== 2'b11 ||
            bus.balance !== BAL_W'(75)) begin
            errors++;
            $display("FAIL coin_in_change: got reject=%0b cv=%0b coin=%0d bal=%0d expected 1 1 3 75",
                     bus.coin_reject, bus.change_valid, bus.change_coin, bus.balance);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.sup_ready !== 1'b0 || bus.change_valid !== 1'b0 || bus.change_coin !== 2'b00 ||
            bus.balance !== '0 || bus.status !== 3'd0 || bus.info !== '0 || bus.coin_reject !== 1'b0 ||
            bus.product_valid !== 1'b0 || bus6.balance !== '0) begin
            errors++;
            $display("FAIL async_reset: got ready=%0b cv=%0b bal=%0d status=%0d info=%0d expected all 0",
                     bus.sup_ready, bus.change_valid, bus.balance, bus.status, bus.info);
        end
        step();
        step();
        checks++;
        if (bus.change_valid !== 1'b0 || bus.balance !== '0) begin
            errors++;
            $display("FAIL reset_hold: got cv=%0b bal=%0d expected 0 0", bus.change_valid, bus.balance);
        end
        rst = 1'b1;
        model_clear();
        step();
        step();
        select_one(3);
        m_status = 3;
        drain("inventory_cleared");
    endtask

    initial begin
        clear_inputs();
        model_clear();
        test_reset();
        test_basic_vend();
        test_insufficient();
        test_multi_select();
        test_sold_out();
        test_timeout();
        test_soft_rst();
        test_load_error();
        test_overflow();
        test_random();
        test_reset_in_change();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
